// File: rtl/smpc_pkg.sv
// Shared types and constants for the SMPC peripheral-port scanners.
// A pad phase's encoding is the {TH,TR} level driven to the port in that phase.
package smpc_pkg;

  typedef enum logic [1:0] {
    PH_ID  = 2'b11,
    PH_DIR = 2'b10,
    PH_BTN = 2'b01,
    PH_TRG = 2'b00
  } PadPhase_t;

  typedef enum logic [4:0] {
    ST_IDLE   = 5'b00001,
    ST_DRIVE  = 5'b00010,
    ST_SETTLE = 5'b00100,
    ST_SAMPLE = 5'b01000,
    ST_DONE   = 5'b10000
  } ScanState_t;

  localparam logic [2:0]  PAD_ID_DIGITAL = 3'b100;
  localparam logic [15:0] JOY_IDLE       = 16'hFFFF;
  localparam logic [6:0]  PORT_DDR_PAD   = 7'b1100000;

  // Phases run 11,10,01,00, so the inverted encoding is the nibble slot 0..3.
  function automatic logic [1:0] phase_slot(input PadPhase_t p);
    return ~p;
  endfunction

  function automatic PadPhase_t next_phase(input PadPhase_t p);
    return PadPhase_t'(p - 2'd1);
  endfunction

  function automatic logic [15:0] pad_word(input logic [3:0] n0, input logic [3:0] n1,
                                           input logic [3:0] n2, input logic [3:0] n3);
    if (n0[2:0] == PAD_ID_DIGITAL) return {n1, n2, n3, n0[3], PAD_ID_DIGITAL};
    return JOY_IDLE;
  endfunction

endpackage

// File: rtl/smpc_pad_scan.sv
// Scans one Saturn digital pad through its four TH/TR phases and publishes
// the 16-bit active-low button word in one step once all nibbles are in.
module smpc_pad_scan
  import smpc_pkg::*;
#(
  parameter int unsigned SETTLE_CYC = 8
) (
  input  logic        CLK,
  input  logic        RST_N,
  input  logic        CE,
  input  logic        SCAN_REQ,
  input  logic [6:0]  P_I,
  output logic [6:0]  P_O,
  output logic [6:0]  P_DDR,
  output logic        BUSY,
  output logic        VALID,
  output logic        CONNECTED,
  output logic [15:0] JOY
);

  localparam logic [7:0] SETTLE_LOAD = 8'(SETTLE_CYC - 1);

  ScanState_t  r_state;
  ScanState_t  w_state_nxt;
  PadPhase_t   r_phase;
  logic [7:0]  r_cnt;
  logic [3:0]  r_nib [4];
  logic [1:0]  r_thtr;
  logic        r_busy;
  logic        r_valid;
  logic        r_connected;
  logic [15:0] r_joy;

  logic w_start;
  logic w_drive;
  logic w_count;
  logic w_sample;
  logic w_done;
  logic w_unused_pins;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_state <= ST_IDLE;
    end else if (CE) begin
      r_state <= w_state_nxt;
    end
  end

  // NOTE: every comb output gets a default first so no path infers a latch.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      ST_IDLE:   if (SCAN_REQ) w_state_nxt = ST_DRIVE;
      ST_DRIVE:  w_state_nxt = ST_SETTLE;
      ST_SETTLE: if (r_cnt == 8'd0) w_state_nxt = ST_SAMPLE;
      ST_SAMPLE: w_state_nxt = (r_phase == PH_TRG) ? ST_DONE : ST_DRIVE;
      ST_DONE:   w_state_nxt = ST_IDLE;
      default:   w_state_nxt = ST_IDLE;
    endcase
  end

  always_comb begin
    w_start  = 1'b0;
    w_drive  = 1'b0;
    w_count  = 1'b0;
    w_sample = 1'b0;
    w_done   = 1'b0;
    case (r_state)
      ST_IDLE:   w_start  = SCAN_REQ;
      ST_DRIVE:  w_drive  = 1'b1;
      ST_SETTLE: w_count  = 1'b1;
      ST_SAMPLE: w_sample = 1'b1;
      ST_DONE:   w_done   = 1'b1;
      default:   ;
    endcase
  end

  // NOTE: the nibble store is reset like any other register, so an aborted
  // scan can never leak stale nibbles into a later result.
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      r_phase     <= PH_ID;
      r_cnt       <= 8'd0;
      r_thtr      <= 2'b11;
      r_busy      <= 1'b0;
      r_valid     <= 1'b0;
      r_connected <= 1'b0;
      r_joy       <= JOY_IDLE;
      for (int i = 0; i < 4; i++) r_nib[i] <= 4'h0;
    end else if (CE) begin
      r_valid <= 1'b0;
      if (w_start) begin
        r_busy  <= 1'b1;
        r_phase <= PH_ID;
      end
      if (w_drive) begin
        r_thtr <= r_phase;
        r_cnt  <= SETTLE_LOAD;
      end
      if (w_count && r_cnt != 8'd0) r_cnt <= r_cnt - 8'd1;
      if (w_sample) begin
        r_nib[phase_slot(r_phase)] <= P_I[3:0];
        if (r_phase != PH_TRG) r_phase <= next_phase(r_phase);
      end
      // Result registers change only here, so a half-scanned word is never visible.
      if (w_done) begin
        r_thtr      <= 2'b11;
        r_busy      <= 1'b0;
        r_valid     <= 1'b1;
        r_joy       <= pad_word(r_nib[0], r_nib[1], r_nib[2], r_nib[3]);
        r_connected <= (r_nib[0][2:0] == PAD_ID_DIGITAL);
      end
    end
  end

  // TH/TR/TL read-back is not needed by the scan.
  assign w_unused_pins = ^P_I[6:4];

  assign P_O       = {r_thtr, 5'b00000};
  assign P_DDR     = PORT_DDR_PAD;
  assign BUSY      = r_busy;
  assign VALID     = r_valid;
  assign CONNECTED = r_connected;
  assign JOY       = r_joy;

endmodule

// File: tb/tb_smpc_pad_scan.sv
// Bench for smpc_pad_scan: a behavioural pad on the port, a scoreboard of
// expected scan results, and a monitor that checks each VALID pulse.
module tb_smpc_pad_scan;

  localparam int SETTLE   = 8;
  localparam int SCAN_LEN = 4 * (SETTLE + 2) + 1;

  typedef struct packed {
    logic l, r, right, left, down, up, start, a, c, b, x, y, z;
  } pad_btn_t;

  typedef struct {
    logic [15:0] joy;
    logic        conn;
    int          req_tick;
  } exp_t;

  logic        CLK = 1'b0;
  logic        RST_N;
  logic        CE;
  logic        SCAN_REQ;
  logic [6:0]  P_I;
  logic [6:0]  P_O;
  logic [6:0]  P_DDR;
  logic        BUSY;
  logic        VALID;
  logic        CONNECTED;
  logic [15:0] JOY;

  pad_btn_t    btn;
  logic        present;
  logic [2:0]  pad_id;
  bit          ce_div = 1'b0;
  int          tick = 0;
  int          total = 0;
  int          bad = 0;
  exp_t        sb[$];
  logic [1:0]  seq[$];
  bit          m_active;
  int          m_busy_until;

  smpc_pad_scan #(.SETTLE_CYC(SETTLE)) dut (
    .CLK       (CLK),
    .RST_N     (RST_N),
    .CE        (CE),
    .SCAN_REQ  (SCAN_REQ),
    .P_I       (P_I),
    .P_O       (P_O),
    .P_DDR     (P_DDR),
    .BUSY      (BUSY),
    .VALID     (VALID),
    .CONNECTED (CONNECTED),
    .JOY       (JOY)
  );

  always #5 CLK = ~CLK;

  // Standard digital pad: each {TH,TR} level selects which buttons appear on D3..D0.
  function automatic logic [3:0] pad_nibble(input logic [1:0] thtr, input pad_btn_t b,
                                            input logic [2:0] id);
    case (thtr)
      2'b11:   return {~b.l, id};
      2'b10:   return {~b.right, ~b.left, ~b.down, ~b.up};
      2'b01:   return {~b.start, ~b.a, ~b.c, ~b.b};
      default: return {~b.r, ~b.x, ~b.y, ~b.z};
    endcase
  endfunction

  assign P_I = present ? {P_O[6:5], 1'b1, pad_nibble(P_O[6:5], btn, pad_id)} : 7'h7F;

  function automatic exp_t expect_scan(input int t);
    exp_t e;
    e.req_tick = t;
    e.joy      = 16'hFFFF;
    e.conn     = 1'b0;
    if (present && pad_id == 3'b100) begin
      e.conn = 1'b1;
      e.joy  = 16'hFFFC;
      if (btn.right) e.joy[15] = 1'b0;
      if (btn.left)  e.joy[14] = 1'b0;
      if (btn.down)  e.joy[13] = 1'b0;
      if (btn.up)    e.joy[12] = 1'b0;
      if (btn.start) e.joy[11] = 1'b0;
      if (btn.a)     e.joy[10] = 1'b0;
      if (btn.c)     e.joy[9]  = 1'b0;
      if (btn.b)     e.joy[8]  = 1'b0;
      if (btn.r)     e.joy[7]  = 1'b0;
      if (btn.x)     e.joy[6]  = 1'b0;
      if (btn.y)     e.joy[5]  = 1'b0;
      if (btn.z)     e.joy[4]  = 1'b0;
      if (btn.l)     e.joy[3]  = 1'b0;
    end
    return e;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  initial begin
    int ce_phase;
    ce_phase = 0;
    CE = 1'b0;
    forever begin
      @(negedge CLK);
      ce_phase = (ce_phase + 1) % 4;
      CE = ce_div ? (ce_phase == 0) : 1'b1;
    end
  end

  initial begin
    forever begin
      @(posedge CLK);
      if (CE === 1'b1) tick++;
    end
  end

  initial begin
    logic [1:0] last;
    last = 2'b11;
    forever begin
      @(negedge CLK);
      if (P_O[6:5] !== last) begin
        seq.push_back(P_O[6:5]);
        last = P_O[6:5];
      end
    end
  end

  // Monitor: one scoreboard entry per VALID pulse, plus latency and pulse width.
  initial begin
    logic prev_v;
    int   rise_tick;
    exp_t e;
    prev_v    = 1'b0;
    rise_tick = 0;
    forever begin
      @(negedge CLK);
      if (VALID === 1'b1 && !prev_v) begin
        rise_tick = tick;
        check("valid_has_request", 32'(sb.size() != 0), 1);
        if (sb.size() != 0) begin
          e = sb.pop_front();
          check("joy", JOY, e.joy);
          check("connected", CONNECTED, e.conn);
          check("latency_ce", tick - e.req_tick, SCAN_LEN);
        end
      end
      if (VALID !== 1'b1 && prev_v) check("valid_width_ce", tick - rise_tick, 1);
      prev_v = (VALID === 1'b1);
    end
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog expired");
  end

  task automatic wait_until_tick(input int n);
    while (tick < n) begin
      @(posedge CLK);
      #1;
    end
  endtask

  // Holds SCAN_REQ for exactly one CE tick; the model decides acceptance.
  task automatic pulse_req(output int t, output bit acc);
    @(negedge CLK);
    SCAN_REQ = 1'b1;
    do @(posedge CLK); while (CE !== 1'b1);
    #1;
    SCAN_REQ = 1'b0;
    t   = tick;
    acc = !m_active || (t > m_busy_until);
    if (acc) begin
      m_active     = 1'b1;
      m_busy_until = t + SCAN_LEN;
      sb.push_back(expect_scan(t));
      seq.delete();
    end
  endtask

  task automatic wait_scan(input int t);
    wait_until_tick(t + 20);
    check("busy_mid_scan", BUSY, 1);
    wait_until_tick(t + SCAN_LEN + 1);
    @(negedge CLK);
    #1;
    check("busy_after_scan", BUSY, 0);
    check("thtr_seq_len", seq.size(), 4);
    if (seq.size() == 4) check("thtr_seq", {seq[0], seq[1], seq[2], seq[3]}, 8'b10_01_00_11);
  endtask

  task automatic do_scan();
    int t;
    bit acc;
    pulse_req(t, acc);
    wait_scan(t);
  endtask

  task automatic set_buttons(input bit a, input bit up, input bit r);
    btn       = '0;
    btn.a     = a;
    btn.up    = up;
    btn.r     = r;
  endtask

  initial begin
    int t0;
    int t1;
    int tx;
    bit acc;
    RST_N        = 1'b0;
    SCAN_REQ     = 1'b0;
    btn          = '0;
    present      = 1'b1;
    pad_id       = 3'b100;
    m_active     = 1'b0;
    m_busy_until = 0;

    repeat (3) @(negedge CLK);
    check("rst_p_o", P_O, 7'h60);
    check("rst_p_ddr", P_DDR, 7'h60);
    check("rst_busy", BUSY, 0);
    check("rst_valid", VALID, 0);
    check("rst_connected", CONNECTED, 0);
    check("rst_joy", JOY, 16'hFFFF);
    @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);

    // No buttons, then A+Up+R trig, then an open port.
    do_scan();
    set_buttons(1'b1, 1'b1, 1'b1);
    do_scan();
    present = 1'b0;
    do_scan();
    check("p_ddr_const", P_DDR, 7'h60);

    // Requests mid-scan and on the DONE tick are dropped; the next tick starts a scan.
    present = 1'b1;
    btn     = '0;
    pulse_req(t0, acc);
    wait_until_tick(t0 + 15);
    pulse_req(tx, acc);
    wait_until_tick(t0 + SCAN_LEN - 1);
    pulse_req(tx, acc);
    pulse_req(t1, acc);
    wait_scan(t1);

    // Slow clock enable: same result, VALID one CE period wide.
    ce_div = 1'b1;
    set_buttons(1'b1, 1'b1, 1'b1);
    do_scan();
    ce_div = 1'b0;
    repeat (4) @(negedge CLK);

    // Reset during SETTLE of phase 2 aborts the scan.
    btn = '0;
    pulse_req(t0, acc);
    wait_until_tick(t0 + 24);
    @(negedge CLK);
    check("pre_rst_busy", BUSY, 1);
    check("pre_rst_thtr", P_O[6:5], 2'b01);
    RST_N = 1'b0;
    #1;
    check("abort_p_o", P_O, 7'h60);
    check("abort_busy", BUSY, 0);
    check("abort_joy", JOY, 16'hFFFF);
    check("abort_connected", CONNECTED, 0);
    check("abort_valid", VALID, 0);
    sb.delete();
    m_active = 1'b0;
    repeat (2) @(negedge CLK);
    RST_N = 1'b1;
    repeat (2) @(negedge CLK);
    set_buttons(1'b0, 1'b1, 1'b0);
    btn.start = 1'b1;
    do_scan();

    // Foreign device ID.
    pad_id = 3'b011;
    do_scan();

    for (int i = 0; i < 6; i++) begin
      btn     = 13'($urandom);
      present = ($urandom_range(0, 4) != 0);
      pad_id  = ($urandom_range(0, 3) == 0) ? 3'($urandom) : 3'b100;
      do_scan();
    end

    repeat (4) @(negedge CLK);
    check("sb_drained", sb.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
